// File: rtl/alu_pkg.sv
// Shared opcode encodings, widths and flag layout for the ALU execute stage.
package alu_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int OPW_DEF   = 3;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_AND     = 3'd2;
  localparam logic [2:0] OP_OR      = 3'd3;
  localparam logic [2:0] OP_XOR     = 3'd4;
  localparam logic [2:0] OP_SLT     = 3'd5;
  localparam logic [2:0] OP_SLTU    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_CARRY   = 1;
  localparam int FLAG_OVF     = 2;
  localparam int FLAG_ILLEGAL = 3;
  localparam int NFLAGS       = 4;

  typedef logic [NFLAGS-1:0] flags_t;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU datapath: op, a, b -> result plus zero/carry/overflow/illegal flags.
module alu_exec_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             slt_lt;
  logic             carry;
  logic             ovf;
  logic             illegal;

  // ADD and SUB share one adder; SUB is A + ~B + 1 so bit WIDTH is the no-borrow flag.
  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  slt u_slt (
    .a  (a),
    .b  (b),
    .lt (slt_lt)
  );

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    result  = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt_lt};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    flags               = '0;
    flags[FLAG_ZERO]    = (result == '0);
    flags[FLAG_CARRY]   = carry;
    flags[FLAG_OVF]     = ovf;
    flags[FLAG_ILLEGAL] = illegal;
  end

endmodule

// File: rtl/slt.sv
// Signed set-less-than unit: lt = (a < b) with both operands as two's complement.
module slt (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        lt
);

  assign lt = ($signed(a) < $signed(b));

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage valid/ready ALU execute pipe: S1 holds the operands, S2 holds the registered result.
module alu_exec_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,  // only 64 is supported: the slt unit is fixed at 64 bits
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_illegal
);

  logic             s1_valid;
  logic [OPW-1:0]   s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_free;
  logic             accept;
  logic             advance;

  logic [WIDTH-1:0] core_result;
  flags_t           core_flags;

  // S2 can take a new op when empty or when its current result leaves this cycle.
  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid && s2_free;

  alu_exec_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_result),
    .flags  (core_flags)
  );

  // NOTE: data registers are reset too, so outputs are deterministic straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_a     <= in_a;
      s1_b     <= in_b;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 drives the outputs directly, so they stay stable while backpressured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_carry   <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
    end else if (advance) begin
      out_valid   <= 1'b1;
      out_result  <= core_result;
      out_zero    <= core_flags[FLAG_ZERO];
      out_carry   <= core_flags[FLAG_CARRY];
      out_ovf     <= core_flags[FLAG_OVF];
      out_illegal <= core_flags[FLAG_ILLEGAL];
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe: single ops, flags, stalled stream, illegal op and async reset.
module tb_alu_exec_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_zero;
  logic        out_carry;
  logic        out_ovf;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  alu_exec_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_carry   (out_carry),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return on the following falling edge, where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One op through an idle pipe with out_ready high: result visible after the second edge.
  task automatic run_single(input string tag, input logic [2:0] op,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] res, input logic z, input logic c,
                            input logic v, input logic ill);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    check({tag, " in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({tag, " early out_valid"}, out_valid, 0);
    step();
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " result"}, out_result, res);
    check({tag, " zero"}, out_zero, z);
    check({tag, " carry"}, out_carry, c);
    check({tag, " ovf"}, out_ovf, v);
    check({tag, " illegal"}, out_illegal, ill);
    step();
    check({tag, " drained"}, out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    #3;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset out_result", out_result, 0);
    check("reset out_zero", out_zero, 0);

    @(negedge clk);
    rst_n = 1'b1;
    check("post-reset in_ready", in_ready, 1);
    step();

    run_single("slt neg", 3'd5, 64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FFFB,
               64'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_single("sltu swapped", 3'd6, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF6,
               64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_single("sltu big vs 5", 3'd6, 64'hFFFF_FFFF_FFFF_FFF6, 64'd5,
               64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_single("slt neg vs 5", 3'd5, 64'hFFFF_FFFF_FFFF_FFF6, 64'd5,
               64'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_single("add ovf", 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
               64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    run_single("sub equal", 3'd1, 64'd5, 64'd5,
               64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_single("add carry", 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
               64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_single("sub ovf", 3'd1, 64'h8000_0000_0000_0000, 64'd1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    run_single("sub borrow", 3'd1, 64'd3, 64'd5,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_single("and", 3'd2, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_single("or", 3'd3, 64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_single("illegal", 3'd7, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Stream of four ops with the sink stalled until both stages fill.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op = 3'd0; in_a = 64'd1; in_b = 64'd2;
    check("stream in_ready 0", in_ready, 1);
    step();
    check("stream in_ready 1", in_ready, 1);
    check("stream out_valid 1", out_valid, 0);
    in_op = 3'd1; in_a = 64'd10; in_b = 64'd3;
    step();
    check("stream full in_ready", in_ready, 0);
    check("stream first valid", out_valid, 1);
    check("stream first result", out_result, 64'd3);
    in_op = 3'd4; in_a = 64'hF0; in_b = 64'h0F;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall %0d in_ready", i), in_ready, 0);
      check($sformatf("stall %0d out_valid", i), out_valid, 1);
      check($sformatf("stall %0d result", i), out_result, 64'd3);
    end
    out_ready = 1'b1;
    step();
    check("stream second valid", out_valid, 1);
    check("stream second result", out_result, 64'd7);
    in_op = 3'd5; in_a = 64'd5; in_b = 64'd10;
    step();
    in_valid = 1'b0;
    check("stream third valid", out_valid, 1);
    check("stream third result", out_result, 64'hFF);
    step();
    check("stream fourth valid", out_valid, 1);
    check("stream fourth result", out_result, 64'd1);
    step();
    check("stream no duplicate", out_valid, 0);

    // Fill both stages, then assert reset between edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op = 3'd0; in_a = 64'd2; in_b = 64'd2;
    step();
    in_op = 3'd3; in_a = 64'd1; in_b = 64'd2;
    step();
    in_valid = 1'b0;
    check("rst pre out_valid", out_valid, 1);
    check("rst pre in_ready", in_ready, 0);
    check("rst pre result", out_result, 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async out_valid", out_valid, 0);
    check("rst async in_ready", in_ready, 1);
    check("rst async result", out_result, 0);
    @(negedge clk);
    check("rst held in_ready", in_ready, 1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    check("rst release in_ready", in_ready, 1);
    step();
    check("rst no stale 0", out_valid, 0);
    step();
    check("rst no stale 1", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
